// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
// regfile_write_arbiter
//   Owns the single write port (Bus/DR/WE) of the LC-3 8x16 register file.
//   The port is shared between requester A (core writeback, normally wins)
//   and requester B (debug/loader port). B is forced through after A has won
//   STARVE_LIMIT times in a row while B was waiting. On command, an init
//   sequence writes INIT_VAL to every register R0..R(NREG-1) in ascending
//   order. All write-port outputs are registered, so an accept in cycle N
//   shows up as WE=1 with the winner's DR/Bus in cycle N+1.
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset
//   i_a_valid    A write request (dr/data held stable until accepted)
//   i_a_dr       A destination register
//   i_a_data     A write data
//   o_a_ready    A accepted this cycle when i_a_valid & o_a_ready
//   i_b_valid    B write request (dr/data held stable until accepted)
//   i_b_dr       B destination register
//   i_b_data     B write data
//   o_b_ready    B accepted this cycle when i_b_valid & o_b_ready
//   i_init_start request the init sequence (only looked at while arbitrating)
//   o_init_busy  high during the init write cycles
//   o_init_done  one-cycle pulse in the first arbitration cycle after init
//   o_bus        register file data input
//   o_dr         register file destination select
//   o_we         register file write enable

module regfile_write_arbiter #(
  parameter int                 WIDTH        = 16,
  parameter int                 AW           = 3,
  parameter logic [WIDTH-1:0]   INIT_VAL     = '0,
  parameter int                 STARVE_LIMIT = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_a_valid,
  input  logic [AW-1:0]    i_a_dr,
  input  logic [WIDTH-1:0] i_a_data,
  output logic             o_a_ready,
  input  logic             i_b_valid,
  input  logic [AW-1:0]    i_b_dr,
  input  logic [WIDTH-1:0] i_b_data,
  output logic             o_b_ready,
  input  logic             i_init_start,
  output logic             o_init_busy,
  output logic             o_init_done,
  output logic [WIDTH-1:0] o_bus,
  output logic [AW-1:0]    o_dr,
  output logic             o_we
);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  localparam logic [3:0]    LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  state_t           r_state;
  state_t           w_stateNext;

  logic [3:0]       r_starveCnt;
  logic [3:0]       w_starveNext;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_idxNext;

  logic             r_we;
  logic             w_weNext;
  logic [AW-1:0]    r_dr;
  logic [AW-1:0]    w_drNext;
  logic [WIDTH-1:0] r_bus;
  logic [WIDTH-1:0] w_busNext;
  logic             r_initBusy;
  logic             w_initBusyNext;
  logic             r_initDone;
  logic             w_initDoneNext;

  logic             w_starved;
  logic             w_arbOpen;
  logic             w_aAccept;
  logic             w_bAccept;

  // The ready handshake is combinational. Arbitration is only open in ARB
  // when no init request is pending and reset is low. A normally wins; once
  // B has been passed over STARVE_LIMIT times, B takes the port and A is
  // held off, so at most one requester is accepted per cycle.
  always_comb begin
    w_starved = (r_starveCnt == LIMIT);
    w_arbOpen = (r_state == ST_ARB) && !i_init_start && !i_reset;
    o_a_ready = w_arbOpen && !(i_b_valid && w_starved);
    o_b_ready = w_arbOpen && (!i_a_valid || w_starved);
    w_aAccept = i_a_valid && o_a_ready;
    w_bAccept = i_b_valid && o_b_ready;
  end

  // Next-state and next-output logic. WE defaults low and DR/Bus hold their
  // last values, so a cycle with no accept leaves the write port idle. The
  // init sequence launches its first write (DR=0) on the same edge that
  // enters INIT, which keeps DR equal to idx in every INIT cycle.
  always_comb begin
    w_stateNext    = r_state;
    w_starveNext   = r_starveCnt;
    w_idxNext      = r_idx;
    w_weNext       = 1'b0;
    w_drNext       = r_dr;
    w_busNext      = r_bus;
    w_initBusyNext = 1'b0;
    w_initDoneNext = 1'b0;

    case (r_state)
      ST_ARB: begin
        // Count consecutive A wins over a waiting B. A cycle in which B
        // goes through, or B is not asking, clears the count.
        if (w_aAccept && i_b_valid) begin
          if (r_starveCnt != LIMIT) begin
            w_starveNext = r_starveCnt + 4'd1;
          end
        end else if (w_bAccept || !i_b_valid) begin
          w_starveNext = 4'd0;
        end

        if (i_init_start) begin
          w_stateNext    = ST_INIT;
          w_idxNext      = '0;
          w_weNext       = 1'b1;
          w_drNext       = '0;
          w_busNext      = INIT_VAL;
          w_initBusyNext = 1'b1;
        end else if (w_aAccept) begin
          w_weNext  = 1'b1;
          w_drNext  = i_a_dr;
          w_busNext = i_a_data;
        end else if (w_bAccept) begin
          w_weNext  = 1'b1;
          w_drNext  = i_b_dr;
          w_busNext = i_b_data;
        end
      end

      ST_INIT: begin
        // The write for the current idx is on the port right now. After the
        // last register, return to ARB and pulse init_done in that cycle.
        if (r_idx == LAST_IDX) begin
          w_stateNext    = ST_ARB;
          w_initDoneNext = 1'b1;
        end else begin
          w_idxNext      = r_idx + 1'b1;
          w_weNext       = 1'b1;
          w_drNext       = r_idx + 1'b1;
          w_busNext      = INIT_VAL;
          w_initBusyNext = 1'b1;
        end
      end

      default: begin
        w_stateNext = ST_ARB;
      end
    endcase
  end

  // State and registered write-port outputs. Reset wins in any state and
  // simply abandons an init sequence in progress without a done pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_ARB;
      r_starveCnt <= 4'd0;
      r_idx       <= '0;
      r_we        <= 1'b0;
      r_dr        <= '0;
      r_bus       <= '0;
      r_initBusy  <= 1'b0;
      r_initDone  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_starveCnt <= w_starveNext;
      r_idx       <= w_idxNext;
      r_we        <= w_weNext;
      r_dr        <= w_drNext;
      r_bus       <= w_busNext;
      r_initBusy  <= w_initBusyNext;
      r_initDone  <= w_initDoneNext;
    end
  end

  assign o_we        = r_we;
  assign o_dr        = r_dr;
  assign o_bus       = r_bus;
  assign o_init_busy = r_initBusy;
  assign o_init_done = r_initDone;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
`timescale 1ns/1ps
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter. A shadow register file is fed
//   from the DUT write port so the bench can check what the LC-3 register
//   file would hold. Inputs change 1ns after a rising edge; registered
//   outputs are checked at that point, combinational readies 1ns later.

module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        aValid;
  logic [2:0]  aDr;
  logic [15:0] aData;
  logic        aReady;
  logic        bValid;
  logic [2:0]  bDr;
  logic [15:0] bData;
  logic        bReady;
  logic        initStart;
  logic        initBusy;
  logic        initDone;
  logic [15:0] bus;
  logic [2:0]  dr;
  logic        we;

  logic [15:0] rfModel [0:7];

  int checks   = 0;
  int failures = 0;

  regfile_write_arbiter #(
    .WIDTH(16), .AW(3), .INIT_VAL(16'h0000), .STARVE_LIMIT(4)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_a_valid(aValid), .i_a_dr(aDr), .i_a_data(aData), .o_a_ready(aReady),
    .i_b_valid(bValid), .i_b_dr(bDr), .i_b_data(bData), .o_b_ready(bReady),
    .i_init_start(initStart), .o_init_busy(initBusy), .o_init_done(initDone),
    .o_bus(bus), .o_dr(dr), .o_we(we)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow register file: what the real 8x16 file would latch.
  always @(posedge clk) begin
    if (we) rfModel[dr] <= bus;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [2:0] ad, input logic [15:0] adata,
                               input logic bv, input logic [2:0] bd, input logic [15:0] bdata,
                               input logic ini);
    aValid    = av;
    aDr       = ad;
    aData     = adata;
    bValid    = bv;
    bDr       = bd;
    bData     = bdata;
    initStart = ini;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int aNum;
    int bNum;
    logic expB;
    logic [15:0] expData;
    logic [2:0] expDr;

    for (int r = 0; r < 8; r++) rfModel[r] = 16'hFFFF;

    // Reset with both requesters asking: readies must stay low.
    reset = 1'b1;
    applyStimulus(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("rstAReady", aReady, 0);
    checkOutput("rstBReady", bReady, 0);
    checkOutput("rstWe", we, 0);
    checkOutput("rstDr", dr, 0);
    checkOutput("rstBus", bus, 0);
    checkOutput("rstBusy", initBusy, 0);
    checkOutput("rstDone", initDone, 0);

    // Test 1: single A write, one-cycle latency.
    reset = 1'b0;
    applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0);
    #1;
    checkOutput("t1AReady", aReady, 1);
    checkOutput("t1BReady", bReady, 0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    checkOutput("t1We", we, 1);
    checkOutput("t1Dr", dr, 3);
    checkOutput("t1Bus", bus, 32'hBEEF);
    nextCycle();
    checkOutput("t1WeOff", we, 0);
    checkOutput("t1DrHold", dr, 3);
    checkOutput("t1BusHold", bus, 32'hBEEF);
    checkOutput("t1R3", rfModel[3], 32'hBEEF);

    // Test 2: both requesting -> A,A,A,A,B,A,A,A,A,B.
    aNum = 0;
    bNum = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 3'(aNum), 16'hA000 + 16'(aNum),
                    1'b1, 3'(7 - bNum), 16'hB000 + 16'(bNum), 1'b0);
      #1;
      expB = (k == 4) || (k == 9);
      checkOutput($sformatf("t2AReady%0d", k), aReady, !expB);
      checkOutput($sformatf("t2BReady%0d", k), bReady, expB);
      expData = expB ? 16'hB000 + 16'(bNum) : 16'hA000 + 16'(aNum);
      expDr   = expB ? 3'(7 - bNum) : 3'(aNum);
      nextCycle();
      checkOutput($sformatf("t2We%0d", k), we, 1);
      checkOutput($sformatf("t2Dr%0d", k), dr, expDr);
      checkOutput($sformatf("t2Bus%0d", k), bus, expData);
      if (expB) bNum++; else aNum++;
    end

    // Test 3: B alone, five back-to-back writes.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'(k), 16'hC000 + 16'(k), 1'b0);
      #1;
      checkOutput($sformatf("t3AReady%0d", k), aReady, 1);
      checkOutput($sformatf("t3BReady%0d", k), bReady, 1);
      nextCycle();
      checkOutput($sformatf("t3We%0d", k), we, 1);
      checkOutput($sformatf("t3Dr%0d", k), dr, k);
      checkOutput($sformatf("t3Bus%0d", k), bus, 32'hC000 + k);
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    nextCycle();
    checkOutput("t3WeOff", we, 0);

    // Test 4: init sequence writes zero to R0..R7.
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    #1;
    checkOutput("t4StartAReady", aReady, 0);
    checkOutput("t4StartBReady", bReady, 0);
    nextCycle();
    initStart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput($sformatf("t4We%0d", i), we, 1);
      checkOutput($sformatf("t4Dr%0d", i), dr, i);
      checkOutput($sformatf("t4Bus%0d", i), bus, 0);
      checkOutput($sformatf("t4Busy%0d", i), initBusy, 1);
      checkOutput($sformatf("t4AReady%0d", i), aReady, 0);
      checkOutput($sformatf("t4BReady%0d", i), bReady, 0);
      checkOutput($sformatf("t4Done%0d", i), initDone, 0);
      nextCycle();
    end
    checkOutput("t4DonePulse", initDone, 1);
    checkOutput("t4DoneWe", we, 0);
    checkOutput("t4DoneBusy", initBusy, 0);
    nextCycle();
    checkOutput("t4DoneLow", initDone, 0);
    for (int r = 0; r < 8; r++) checkOutput($sformatf("t4R%0d", r), rfModel[r], 0);

    // Test 5: init_start together with pending A and B requests.
    applyStimulus(1'b1, 3'd5, 16'h1234, 1'b1, 3'd6, 16'h5678, 1'b1);
    #1;
    checkOutput("t5StartAReady", aReady, 0);
    checkOutput("t5StartBReady", bReady, 0);
    nextCycle();
    initStart = 1'b0;
    checkOutput("t5FirstDr", dr, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput($sformatf("t5AReady%0d", i), aReady, 0);
      nextCycle();
    end
    #1;
    checkOutput("t5DonePulse", initDone, 1);
    checkOutput("t5DoneAReady", aReady, 1);
    checkOutput("t5DoneBReady", bReady, 0);
    nextCycle();
    aValid = 1'b0;
    checkOutput("t5AWe", we, 1);
    checkOutput("t5ADr", dr, 5);
    checkOutput("t5ABus", bus, 32'h1234);
    #1;
    checkOutput("t5BReady", bReady, 1);
    nextCycle();
    bValid = 1'b0;
    checkOutput("t5BWe", we, 1);
    checkOutput("t5BDr", dr, 6);
    checkOutput("t5BBus", bus, 32'h5678);
    nextCycle();
    checkOutput("t5WeOff", we, 0);

    // Test 6: reset while the init sequence is writing R4.
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    nextCycle();
    initStart = 1'b0;
    for (int i = 0; i < 4; i++) nextCycle();
    checkOutput("t6DrAt4", dr, 4);
    checkOutput("t6BusyAt4", initBusy, 1);
    reset = 1'b1;
    applyStimulus(1'b1, 3'd2, 16'h7777, 1'b0, 3'd0, 16'h0, 1'b0);
    #1;
    checkOutput("t6RstAReady", aReady, 0);
    nextCycle();
    checkOutput("t6RstWe", we, 0);
    checkOutput("t6RstBusy", initBusy, 0);
    checkOutput("t6RstDone", initDone, 0);
    reset = 1'b0;
    #1;
    checkOutput("t6AReady", aReady, 1);
    nextCycle();
    aValid = 1'b0;
    checkOutput("t6We", we, 1);
    checkOutput("t6Dr", dr, 2);
    checkOutput("t6Bus", bus, 32'h7777);
    checkOutput("t6NoDone", initDone, 0);
    nextCycle();
    checkOutput("t6WeOff", we, 0);
    checkOutput("t6R2", rfModel[2], 32'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
